// File: rtl/unidade_controle_pkg.sv
// Shared constants for the unidade_controle slice: opcodes, FSM states,
// instruction classes and write-data mux encodings. Optional macro: UC_HALT_EN.
package unidade_controle_pkg;

  localparam logic [3:0] OP_LD   = 4'h0;
  localparam logic [3:0] OP_ST   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_SLL1 = 4'h8;
  localparam logic [3:0] OP_SRL1 = 4'h9;
  localparam logic [3:0] OP_BRZR = 4'hA;
  localparam logic [3:0] OP_JI   = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic SEL_ALU   = 1'b0;
  localparam logic SEL_INSTR = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM
`ifdef UC_HALT_EN
    , ST_HALT
`endif
  } uc_state_t;

  typedef enum logic [2:0] {
    CL_LD,
    CL_ST,
    CL_ALU,
    CL_BRZR,
    CL_JI,
    CL_NOP
`ifdef UC_HALT_EN
    , CL_HALT
`endif
  } uc_class_t;

  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/unidade_controle_if.sv
// Bus between the control unit and its memory / register bank / ALU.
// state is a debug copy of the FSM register for checkers.
interface unidade_controle_if;
  import unidade_controle_pkg::*;

  logic [7:0] instr;
  logic [7:0] s_ra;
  logic [7:0] s_rb;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       rw;
  logic       sel_dado;
  logic [3:0] alu_op;
  logic [7:0] pc;
  logic       halted;
  uc_state_t  state;

  modport master (
    input  instr, s_ra, s_rb,
    output mem_addr, mem_we, ra, rb, rw, sel_dado, alu_op, pc, halted, state
  );

  modport slave (
    output instr, s_ra, s_rb,
    input  mem_addr, mem_we, ra, rb, rw, sel_dado, alu_op, pc, halted, state
  );
endinterface

// File: rtl/unidade_controle_decodificador.sv
// Combinational decoder: splits ir into fields and an instruction class.
// Optional macro: UC_HALT_EN (opcode 0xF is a NOP without it).
module unidade_controle_decodificador
  import unidade_controle_pkg::*;
(
  input  logic [7:0] i_ir,
  output uc_class_t  o_class,
  output logic [3:0] o_opcode,
  output logic [1:0] o_ra,
  output logic [1:0] o_rb,
  output logic [7:0] o_simm
);

  assign o_opcode = i_ir[7:4];
  assign o_ra     = i_ir[3:2];
  assign o_rb     = i_ir[1:0];
  assign o_simm   = sext4(i_ir[3:0]);

  always_comb begin
    o_class = CL_NOP;
    case (i_ir[7:4])
      OP_LD:   o_class = CL_LD;
      OP_ST:   o_class = CL_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOT, OP_SLL1, OP_SRL1:
               o_class = CL_ALU;
      OP_BRZR: o_class = CL_BRZR;
      OP_JI:   o_class = CL_JI;
`ifdef UC_HALT_EN
      OP_HALT: o_class = CL_HALT;
`endif
      default: o_class = CL_NOP;
    endcase
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC[/MEM] sequencing of an 8-bit ISA.
// Optional macro: UC_HALT_EN enables the HALT state for opcode 0xF.
module unidade_controle
  import unidade_controle_pkg::*;
(
  input  logic clk,
  input  logic r,
  unidade_controle_if.master bus
);

  uc_state_t  r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic [7:0] w_mem_addr;
  logic       w_mem_we, w_rw, w_sel_dado;

  uc_class_t  w_class;
  logic [3:0] w_opcode;
  logic [1:0] w_ra, w_rb;
  logic [7:0] w_simm;

  unidade_controle_decodificador u_dec (
    .i_ir     (r_ir),
    .o_class  (w_class),
    .o_opcode (w_opcode),
    .o_ra     (w_ra),
    .o_rb     (w_rb),
    .o_simm   (w_simm)
  );

  always_ff @(posedge clk) begin
    if (r) begin
      r_state <= ST_FETCH;
      r_pc    <= 8'h00;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_mem_addr  = r_pc;
    w_mem_we    = 1'b0;
    w_rw        = 1'b0;
    w_sel_dado  = SEL_ALU;
    case (r_state)
      ST_FETCH: begin
        w_ir_nxt    = bus.instr;
        w_pc_nxt    = r_pc + 8'd1;
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        w_state_nxt = ST_FETCH;
        case (w_class)
          CL_ALU: w_rw = 1'b1;
          CL_LD: begin
            w_mem_addr  = bus.s_rb;
            w_state_nxt = ST_MEM;
          end
          CL_ST: begin
            w_mem_addr = bus.s_rb;
            w_mem_we   = 1'b1;
          end
          CL_BRZR: if (bus.s_ra == 8'h00) w_pc_nxt = bus.s_rb;
          // pc already points past this instruction, so step back one first
          CL_JI: w_pc_nxt = (r_pc - 8'd1) + w_simm;
`ifdef UC_HALT_EN
          CL_HALT: w_state_nxt = ST_HALT;
`endif
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_addr  = bus.s_rb;
        w_rw        = 1'b1;
        w_sel_dado  = SEL_INSTR;
        w_state_nxt = ST_FETCH;
      end
`ifdef UC_HALT_EN
      ST_HALT: w_state_nxt = ST_HALT;
`endif
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  // Strobes are masked by r so a write in flight never lands in a reset cycle.
  assign bus.mem_addr = w_mem_addr;
  assign bus.mem_we   = w_mem_we & ~r;
  assign bus.rw       = w_rw & ~r;
  assign bus.sel_dado = w_sel_dado & ~r;
  assign bus.ra       = w_ra;
  assign bus.rb       = w_rb;
  assign bus.alu_op   = w_opcode;
  assign bus.pc       = r_pc;
  assign bus.state    = r_state;
`ifdef UC_HALT_EN
  assign bus.halted   = (r_state == ST_HALT);
`else
  assign bus.halted   = 1'b0;
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a small instruction memory model.
// Honours UC_HALT_EN for the 0xF step.
module tb_unidade_controle;
  import unidade_controle_pkg::*;

  logic clk;
  logic r;
  logic [7:0] mem [256];
  int n_checks;
  int n_fail;

  unidade_controle_if u_if ();

  unidade_controle dut (
    .clk (clk),
    .r   (r),
    .bus (u_if.master)
  );

  assign u_if.instr = mem[u_if.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    mem[8'h00] = 8'h26;  // ADD r1,r2
    mem[8'h01] = 8'h03;  // LD r0,r3
    mem[8'h02] = 8'hA1;  // BRZR r0,r1
    mem[8'h20] = 8'hA1;  // BRZR r0,r1
    mem[8'h21] = 8'h1B;  // ST r2,r3
    mem[8'h22] = 8'hA1;  // BRZR r0,r1
    mem[8'hFF] = 8'hB1;  // JI +1

    // reset
    r = 1'b1; u_if.s_ra = 8'h00; u_if.s_rb = 8'h00;
    tick(); tick(); #1;
    chk("rst_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("rst_pc", 32'(u_if.pc), 32'h00);
    chk("rst_halted", 32'(u_if.halted), 32'h0);
    chk("rst_rw", 32'(u_if.rw), 32'h0);
    chk("rst_mem_we", 32'(u_if.mem_we), 32'h0);
    chk("rst_sel", 32'(u_if.sel_dado), 32'h0);
    chk("rst_alu_op", 32'(u_if.alu_op), 32'h0);

    // ADD r1,r2
    r = 1'b0; u_if.s_rb = 8'h05; #1;
    chk("add_fetch_addr", 32'(u_if.mem_addr), 32'h00);
    tick();
    chk("add_dec_state", 32'(u_if.state), 32'(ST_DECODE));
    chk("add_dec_ra", 32'(u_if.ra), 32'h1);
    chk("add_dec_rb", 32'(u_if.rb), 32'h2);
    chk("add_dec_rw", 32'(u_if.rw), 32'h0);
    chk("add_dec_addr", 32'(u_if.mem_addr), 32'h01);
    tick();
    chk("add_ex_rw", 32'(u_if.rw), 32'h1);
    chk("add_ex_sel", 32'(u_if.sel_dado), 32'h0);
    chk("add_ex_alu_op", 32'(u_if.alu_op), 32'h2);
    chk("add_ex_ra", 32'(u_if.ra), 32'h1);
    chk("add_ex_pc", 32'(u_if.pc), 32'h01);
    chk("add_ex_we", 32'(u_if.mem_we), 32'h0);
    tick();
    chk("add_done_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("add_done_rw", 32'(u_if.rw), 32'h0);

    // LD r0,r3
    u_if.s_rb = 8'h40; #1;
    chk("ld_fetch_addr", 32'(u_if.mem_addr), 32'h01);
    tick();
    chk("ld_dec_rw", 32'(u_if.rw), 32'h0);
    chk("ld_dec_addr", 32'(u_if.mem_addr), 32'h02);
    tick();
    chk("ld_ex_addr", 32'(u_if.mem_addr), 32'h40);
    chk("ld_ex_rw", 32'(u_if.rw), 32'h0);
    chk("ld_ex_sel", 32'(u_if.sel_dado), 32'h0);
    tick();
    chk("ld_mem_state", 32'(u_if.state), 32'(ST_MEM));
    chk("ld_mem_addr", 32'(u_if.mem_addr), 32'h40);
    chk("ld_mem_rw", 32'(u_if.rw), 32'h1);
    chk("ld_mem_sel", 32'(u_if.sel_dado), 32'h1);
    tick();
    chk("ld_next_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("ld_next_addr", 32'(u_if.mem_addr), 32'h02);
    chk("ld_next_rw", 32'(u_if.rw), 32'h0);
    chk("ld_next_sel", 32'(u_if.sel_dado), 32'h0);

    // BRZR taken
    u_if.s_ra = 8'h00; u_if.s_rb = 8'h20;
    tick(); tick(); tick();
    chk("brzr_taken_addr", 32'(u_if.mem_addr), 32'h20);
    chk("brzr_taken_state", 32'(u_if.state), 32'(ST_FETCH));

    // BRZR not taken
    u_if.s_ra = 8'h01; u_if.s_rb = 8'h30;
    tick(); tick(); tick();
    chk("brzr_nt_addr", 32'(u_if.mem_addr), 32'h21);

    // ST r2,r3
    u_if.s_ra = 8'h55; u_if.s_rb = 8'h80;
    tick();
    chk("st_dec_we", 32'(u_if.mem_we), 32'h0);
    tick();
    chk("st_ex_we", 32'(u_if.mem_we), 32'h1);
    chk("st_ex_addr", 32'(u_if.mem_addr), 32'h80);
    chk("st_ex_rw", 32'(u_if.rw), 32'h0);
    tick();
    chk("st_next_we", 32'(u_if.mem_we), 32'h0);
    chk("st_next_addr", 32'(u_if.mem_addr), 32'h22);

    // branch back to 0x01, which now holds JI -2
    mem[8'h01] = 8'hBE;
    u_if.s_ra = 8'h00; u_if.s_rb = 8'h01;
    tick(); tick(); tick();
    chk("br_to_01_addr", 32'(u_if.mem_addr), 32'h01);
    tick(); tick(); tick();
    chk("ji_back_addr", 32'(u_if.mem_addr), 32'hFF);
    tick();
    chk("pc_wrap", 32'(u_if.pc), 32'h00);
    tick(); tick();
    chk("ji_fwd_wrap_addr", 32'(u_if.mem_addr), 32'h00);

    // NOP
    mem[8'h00] = 8'hC0;
    tick(); tick();
    chk("nop_ex_rw", 32'(u_if.rw), 32'h0);
    chk("nop_ex_we", 32'(u_if.mem_we), 32'h0);
    chk("nop_ex_addr", 32'(u_if.mem_addr), 32'h01);
    tick();
    chk("nop_next_addr", 32'(u_if.mem_addr), 32'h01);

    // LD interrupted by reset in MEM
    mem[8'h01] = 8'h03; u_if.s_rb = 8'h40;
    tick(); tick(); tick();
    chk("ldr_mem_rw", 32'(u_if.rw), 32'h1);
    r = 1'b1; #1;
    chk("ldr_during_rw", 32'(u_if.rw), 32'h0);
    chk("ldr_during_sel", 32'(u_if.sel_dado), 32'h0);
    tick();
    chk("ldr_after_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("ldr_after_pc", 32'(u_if.pc), 32'h00);
    chk("ldr_after_rw", 32'(u_if.rw), 32'h0);
    r = 1'b0; #1;
    chk("ldr_after_addr", 32'(u_if.mem_addr), 32'h00);
    chk("ldr_after_rw_rel", 32'(u_if.rw), 32'h0);

    // opcode 0xF
    mem[8'h00] = 8'hF0;
    tick(); tick(); tick();
`ifdef UC_HALT_EN
    chk("halt_state", 32'(u_if.state), 32'(ST_HALT));
    chk("halt_flag", 32'(u_if.halted), 32'h1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("halt_hold", 32'(u_if.halted), 32'h1);
      chk("halt_pc", 32'(u_if.pc), 32'h01);
      chk("halt_rw", 32'(u_if.rw), 32'h0);
    end
    r = 1'b1;
    tick();
    chk("halt_rst_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("halt_rst_flag", 32'(u_if.halted), 32'h0);
    chk("halt_rst_pc", 32'(u_if.pc), 32'h00);
    r = 1'b0;
`else
    chk("f_nop_state", 32'(u_if.state), 32'(ST_FETCH));
    chk("f_nop_halted", 32'(u_if.halted), 32'h0);
    chk("f_nop_addr", 32'(u_if.mem_addr), 32'h01);
    mem[8'h01] = 8'hC0;
    tick(); tick(); tick();
    chk("f_nop_next_pc", 32'(u_if.pc), 32'h02);
    chk("f_nop_next_halted", 32'(u_if.halted), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
